cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have inputs i_pmem_read (1) and i_pmem_address (lc3b_word): instruction-cache miss request.
REQ-004 SHALL have outputs i_pmem_resp (1) and i_pmem_rdata (lc3b_block, 128): instruction-cache response.
REQ-005 SHALL have inputs d_pmem_read (1), d_pmem_write (1), d_pmem_address (lc3b_word) and d_pmem_wdata (lc3b_block): data-cache request.
REQ-006 SHALL have outputs d_pmem_resp (1) and d_pmem_rdata (lc3b_block): data-cache response.
REQ-007 SHALL have outputs pmem_read (1), pmem_write (1), pmem_address (lc3b_word) and pmem_wdata (lc3b_block): shared downstream memory port.
REQ-008 SHALL have inputs pmem_resp (1) and pmem_rdata (lc3b_block): downstream completion and read data.

Function
REQ-009 SHALL implement FSM states s_idle, s_ifetch, s_data and s_done.
REQ-010 s_idle: no request -> stay; only i_pmem_read -> s_ifetch; only d_pmem_read or d_pmem_write -> s_data; both -> winner per REQ-019/020.
REQ-011 Grant SHALL be registered: a request first sampled in s_idle at edge N drives the downstream port from cycle N+1.
REQ-012 In s_ifetch: pmem_read=1, pmem_write=0, pmem_address=i_pmem_address, pmem_wdata=0.
REQ-013 In s_data: pmem_read/pmem_write/pmem_address/pmem_wdata pass through the d_pmem_* inputs.
REQ-014 Granted requester's resp SHALL equal pmem_resp in the same cycle (combinational); the other requester's resp SHALL be 0.
REQ-015 i_pmem_rdata and d_pmem_rdata SHALL both always equal pmem_rdata.
REQ-016 s_ifetch/s_data SHALL hold until pmem_resp=1, then go to s_done; deasserting the request mid-transaction SHALL NOT abort the grant.
REQ-017 s_done SHALL drive pmem_read=pmem_write=0 and both resps 0 for exactly one cycle, then go to s_idle (absorbs stale requests after resp).
REQ-018 d_pmem_read and d_pmem_write both high SHALL be forwarded unchanged; no arbitration between them.

Configuration
REQ-019 Without macro CACHE_ARBITER_RR_EN: on simultaneous requests in s_idle, data cache SHALL always win.
REQ-020 With CACHE_ARBITER_RR_EN: a 1-bit last_grant register (reset 0 = data) SHALL make the requester not granted last win ties; last_grant updates on every entry to s_ifetch/s_data.

Reset
REQ-021 reset=1 at an edge SHALL force s_idle (and last_grant=0 if enabled) regardless of state, including mid-transaction.
REQ-022 After reset: pmem_read=0, pmem_write=0, i_pmem_resp=0, d_pmem_resp=0, pmem_address=0, pmem_wdata=0.
REQ-023 A pmem_resp arriving in the reset cycle or in s_idle SHALL be ignored.

Structure
REQ-024 lc3b_word and lc3b_block SHALL come from shared package lc3b_types; FSM state enum SHALL be local to the module.
REQ-025 No sub-module; single module, target 120-250 lines RTL.

Verification
REQ-026 I-only: i_pmem_read=1, addr 0x1230, pmem_resp after 4 cycles with rdata 0xAA..AA -> pmem_read high from cycle+1, i_pmem_resp=1 one cycle with rdata 0xAA..AA, then one s_done cycle.
REQ-027 D-write: d_pmem_write=1, addr 0x4560, wdata 0x55..55 -> pmem_write=1, pmem_address=0x4560, pmem_wdata=0x55..55 until pmem_resp; d_pmem_resp pulses once; i_pmem_resp stays 0.
REQ-028 Tie, macro off: both request at same edge -> data served first (addr 0x4560), ifetch (0x1230) after s_done; repeat tie -> data first again.
REQ-029 Tie, CACHE_ARBITER_RR_EN: three back-to-back ties -> grant order data, ifetch, data.
REQ-030 Reset mid-s_data with pmem_resp pending -> next cycle pmem_read=pmem_write=0, state s_idle, late pmem_resp produces no d_pmem_resp.
REQ-031 Stale request: cache holds i_pmem_read one cycle past i_pmem_resp -> no second downstream read issued.

Source files
------------

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word and cache-block types
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_block;
endpackage

// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - I-cache, D-cache and downstream memory bundle for cache_arbiter
interface cache_arbiter_if;
  import lc3b_types::*;

  // instruction-cache side
  logic      i_pmem_read;
  lc3b_word  i_pmem_address;
  logic      i_pmem_resp;
  lc3b_block i_pmem_rdata;

  // data-cache side
  logic      d_pmem_read;
  logic      d_pmem_write;
  lc3b_word  d_pmem_address;
  lc3b_block d_pmem_wdata;
  logic      d_pmem_resp;
  lc3b_block d_pmem_rdata;

  // shared downstream memory port
  logic      pmem_read;
  logic      pmem_write;
  lc3b_word  pmem_address;
  lc3b_block pmem_wdata;
  logic      pmem_resp;
  lc3b_block pmem_rdata;

  // arbiter view
  modport master (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_resp, i_pmem_rdata,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_resp, d_pmem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  // caches and memory view
  modport slave (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_resp, i_pmem_rdata,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_resp, d_pmem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - I/D cache arbiter onto one memory port; CACHE_ARBITER_RR_EN enables round-robin ties
module cache_arbiter
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           reset,
  cache_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    s_idle   = 2'd0,
    s_ifetch = 2'd1,
    s_data   = 2'd2,
    s_done   = 2'd3
  } state_t;

  state_t state;
  state_t next_state;
  logic   i_req;
  logic   d_req;
  logic   pick_data;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;

`ifdef CACHE_ARBITER_RR_EN
  // 1 = data cache took the previous grant; reset clears it so the first tie goes to data
  logic last_grant;

  assign pick_data = d_req & (~i_req | ~last_grant);

  // remember who was granted on every transition out of s_idle
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if (state == s_idle && next_state == s_data) begin
      last_grant <= 1'b1;
    end else if (state == s_idle && next_state == s_ifetch) begin
      last_grant <= 1'b0;
    end
  end
`else
  assign pick_data = d_req;
`endif

  // read data is broadcast; only the resp strobe tells a cache it is the owner
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= s_idle;
    end else begin
      state <= next_state;
    end
  end

  // next-state and downstream/response muxing
  always_comb begin
    next_state       = state;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.i_pmem_resp  = 1'b0;
    bus.d_pmem_resp  = 1'b0;
    case (state)
      s_idle: begin
        if (pick_data) begin
          next_state = s_data;
        end else if (i_req) begin
          next_state = s_ifetch;
        end
      end
      s_ifetch: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = bus.i_pmem_address;
        bus.i_pmem_resp  = bus.pmem_resp;
        if (bus.pmem_resp) begin
          next_state = s_done;
        end
      end
      s_data: begin
        bus.pmem_read    = bus.d_pmem_read;
        bus.pmem_write   = bus.d_pmem_write;
        bus.pmem_address = bus.d_pmem_address;
        bus.pmem_wdata   = bus.d_pmem_wdata;
        bus.d_pmem_resp  = bus.pmem_resp;
        if (bus.pmem_resp) begin
          next_state = s_done;
        end
      end
      s_done: begin
        // one dead cycle lets a cache drop its request before we look again
        next_state = s_idle;
      end
      default: begin
        next_state = s_idle;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - randomized self-checking bench for cache_arbiter
module tb_cache_arbiter;
  import lc3b_types::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  // reference model: outstanding requests and last tie-relevant grant
  bit   pend_i;
  bit   pend_d;
  bit   m_last_data;

  cache_arbiter_if bus();

  cache_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic lc3b_block rnd_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, ".pmem_read"},   bus.pmem_read,   1'b0);
    chk({tag, ".pmem_write"},  bus.pmem_write,  1'b0);
    chk({tag, ".i_pmem_resp"}, bus.i_pmem_resp, 1'b0);
    chk({tag, ".d_pmem_resp"}, bus.d_pmem_resp, 1'b0);
  endtask

  task automatic chk_idle(input string tag);
    chk_quiet(tag);
    chk({tag, ".pmem_address"}, bus.pmem_address, 16'h0);
    chk({tag, ".pmem_wdata"},   bus.pmem_wdata,   128'h0);
  endtask

  task automatic chk_grant(input string tag, input bit win_d);
    if (win_d) begin
      chk({tag, ".d.pmem_read"},    bus.pmem_read,    bus.d_pmem_read);
      chk({tag, ".d.pmem_write"},   bus.pmem_write,   bus.d_pmem_write);
      chk({tag, ".d.pmem_address"}, bus.pmem_address, bus.d_pmem_address);
      chk({tag, ".d.pmem_wdata"},   bus.pmem_wdata,   bus.d_pmem_wdata);
    end else begin
      chk({tag, ".i.pmem_read"},    bus.pmem_read,    1'b1);
      chk({tag, ".i.pmem_write"},   bus.pmem_write,   1'b0);
      chk({tag, ".i.pmem_address"}, bus.pmem_address, bus.i_pmem_address);
      chk({tag, ".i.pmem_wdata"},   bus.pmem_wdata,   128'h0);
    end
  endtask

  task automatic drop_req(input bit win_d);
    if (win_d) begin
      bus.d_pmem_read  = 1'b0;
      bus.d_pmem_write = 1'b0;
    end else begin
      bus.i_pmem_read = 1'b0;
    end
  endtask

  // one arbitration round, entered and left at #1 after an edge with the DUT idle
  task automatic round(input string tag,
                       input bit add_i, input lc3b_word ia,
                       input bit add_d, input bit dr, input bit dw,
                       input lc3b_word da, input lc3b_block dwd,
                       input int lat, input lc3b_block rdata,
                       input bit spur, input bit stale, input bit hold_resp, input bit drop);
    bit win_d;
    if (add_i && !pend_i) begin
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = ia;
      pend_i = 1'b1;
    end
    if (add_d && !pend_d) begin
      bus.d_pmem_read    = dr;
      bus.d_pmem_write   = dw;
      bus.d_pmem_address = da;
      bus.d_pmem_wdata   = dwd;
      pend_d = 1'b1;
    end
    // a completion pulse while idle must never reach either cache
    bus.pmem_resp  = spur;
    bus.pmem_rdata = rnd_block();
    @(negedge clk);
    chk_idle({tag, ".idle"});
    if (!pend_i && !pend_d) begin
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;
      return;
    end
    if (pend_i && pend_d) begin
`ifdef CACHE_ARBITER_RR_EN
      win_d = !m_last_data;
`else
      win_d = 1'b1;
`endif
    end else begin
      win_d = pend_d;
    end
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    for (int k = 0; k < lat; k++) begin
      if (drop && k == 0) drop_req(win_d);
      @(negedge clk);
      chk_grant({tag, ".busy"}, win_d);
      chk({tag, ".busy.i_pmem_resp"}, bus.i_pmem_resp, 1'b0);
      chk({tag, ".busy.d_pmem_resp"}, bus.d_pmem_resp, 1'b0);
      @(posedge clk); #1;
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = rdata;
    @(negedge clk);
    chk_grant({tag, ".resp"}, win_d);
    chk({tag, ".resp.i_pmem_resp"},  bus.i_pmem_resp,  !win_d);
    chk({tag, ".resp.d_pmem_resp"},  bus.d_pmem_resp,  win_d);
    chk({tag, ".resp.i_pmem_rdata"}, bus.i_pmem_rdata, rdata);
    chk({tag, ".resp.d_pmem_rdata"}, bus.d_pmem_rdata, rdata);
    @(posedge clk); #1;
    bus.pmem_resp = hold_resp;
    if (!stale) drop_req(win_d);
    @(negedge clk);
    chk_quiet({tag, ".done"});
    @(posedge clk); #1;
    drop_req(win_d);
    bus.pmem_resp = 1'b0;
    if (win_d) pend_d = 1'b0;
    else       pend_i = 1'b0;
    m_last_data = win_d;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    pend_i = 1'b0;
    pend_d = 1'b0;
    m_last_data = 1'b0;

    // reset with requests and a completion all active
    reset              = 1'b1;
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 16'h1230;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 16'h4560;
    bus.d_pmem_wdata   = rnd_block();
    bus.pmem_resp      = 1'b1;
    bus.pmem_rdata     = rnd_block();
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    reset            = 1'b0;
    bus.i_pmem_read  = 1'b0;
    bus.d_pmem_read  = 1'b0;
    bus.d_pmem_write = 1'b0;
    bus.pmem_resp    = 1'b0;

    // instruction fetch alone, held one cycle past its response
    round("ifetch", 1, 16'h1230, 0, 0, 0, 16'h0, 128'h0, 4,
          {16{8'hAA}}, 0, 1, 0, 0);
    // data-cache write alone, memory keeps resp high into the dead cycle
    round("dwrite", 0, 16'h0, 1, 0, 1, 16'h4560, {16{8'h55}}, 4,
          rnd_block(), 1, 0, 1, 0);
    // read and write together are forwarded untouched
    round("drw", 0, 16'h0, 1, 1, 1, 16'h7770, rnd_block(), 2,
          rnd_block(), 0, 0, 0, 0);
    // ties: both caches request at the same edge, losers stay pending
    round("tie1", 1, 16'h1230, 1, 1, 0, 16'h4560, rnd_block(), 1,
          rnd_block(), 0, 0, 0, 0);
    round("tie2", 0, 16'h0, 1, 1, 0, 16'h4560, rnd_block(), 1,
          rnd_block(), 0, 0, 0, 0);
    round("tie3", 1, 16'h1230, 1, 1, 0, 16'h4560, rnd_block(), 1,
          rnd_block(), 0, 0, 0, 0);
    while (pend_i || pend_d) begin
      round("drain", 0, 16'h0, 0, 0, 0, 16'h0, 128'h0, 1,
            rnd_block(), 0, 0, 0, 0);
    end

    // reset lands while a data read is waiting for memory
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 16'h4560;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid.pre.pmem_read", bus.pmem_read, 1'b1);
    @(posedge clk); #1;
    reset         = 1'b1;
    bus.pmem_resp = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_idle("rstmid.in");
    @(posedge clk); #1;
    reset           = 1'b0;
    bus.d_pmem_read = 1'b0;
    @(negedge clk);
    chk_idle("rstmid.late");
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    m_last_data   = 1'b0;
    @(negedge clk);
    chk_idle("rstmid.after");
    @(posedge clk); #1;

    // randomized traffic
    for (int r = 0; r < 60; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      round("rand",
            bit'($urandom_range(0, 1)), lc3b_word'($urandom),
            bit'($urandom_range(0, 1)), sel[0], sel[1],
            lc3b_word'($urandom), rnd_block(),
            $urandom_range(0, 4), rnd_block(),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end
    while (pend_i || pend_d) begin
      round("rdrain", 0, 16'h0, 0, 0, 0, 16'h0, 128'h0, 1,
            rnd_block(), 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
